// File: rtl/tick_pkg.sv
// rtl/tick_pkg.sv - shared constants, types and helpers for the tick scheduler
// Purpose: default widths/divisor, channel index names and the pending-slot
//          state type used by tick_sched, tick_chan and tick_sched_if.
// Ports:   none (package).
package tick_pkg;

  localparam int TICK_N_CH    = 3;
  localparam int TICK_CNT_W   = 16;
  localparam int TICK_DEF_DIV = 2;

  localparam int CH_PIX  = 0;
  localparam int CH_BAUD = 1;
  localparam int CH_SCAN = 2;

  typedef enum logic {
    PEND_EMPTY = 1'b0,
    PEND_FULL  = 1'b1
  } pend_state_t;

  // Channel index width; a single channel still needs a one-bit index field.
  function automatic int ch_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tick_sched_if.sv
// rtl/tick_sched_if.sv - divisor configuration port of the tick scheduler
// Purpose: groups the valid/ready config request and its error pulse.
// Ports:   cfg_valid/cfg_ch/cfg_div driven by master, cfg_ready/cfg_err
//          driven by slave (the scheduler).
interface tick_sched_if #(
  parameter int N_CH  = tick_pkg::TICK_N_CH,
  parameter int CNT_W = tick_pkg::TICK_CNT_W
);
  import tick_pkg::*;

  localparam int CH_W = ch_width(N_CH);

  logic             cfg_valid;
  logic             cfg_ready;
  logic [CH_W-1:0]  cfg_ch;
  logic [CNT_W-1:0] cfg_div;
  logic             cfg_err;

  modport master (
    output cfg_valid, cfg_ch, cfg_div,
    input  cfg_ready, cfg_err
  );

  modport slave (
    input  cfg_valid, cfg_ch, cfg_div,
    output cfg_ready, cfg_err
  );

endinterface

// File: rtl/tick_chan.sv
// rtl/tick_chan.sv - one programmable divide-by-D tick channel
// Purpose: counter, wrap detect and divisor register for a single channel.
// Ports:   clk, rst_n       clock, async active-low reset
//          i_en, i_sync     global run enable, phase-align pulse
//          i_ld, i_ld_div   a divisor update is pending for this channel
//          i_ld_now         apply the update without waiting for a wrap
//          o_tick           registered one-cycle enable pulse
//          o_applied        update is taken at this edge (comb)
module tick_chan import tick_pkg::*; #(
  parameter int CNT_W   = TICK_CNT_W,
  parameter int DEF_DIV = TICK_DEF_DIV
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_en,
  input  logic             i_sync,
  input  logic             i_ld,
  input  logic [CNT_W-1:0] i_ld_div,
  input  logic             i_ld_now,
  output logic             o_tick,
  output logic             o_applied
);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_div;
  logic             w_run;
  logic             w_wrap;
  logic             w_apply;

  // A divisor of zero parks the channel exactly like en=0 does.
  assign w_run     = i_en && !i_sync && (r_div != '0);
  assign w_wrap    = w_run && (r_cnt == r_div - CNT_W'(1));
  // While running, the new divisor waits for the wrap so no period is cut short.
  assign w_apply   = i_ld && (i_ld_now || (r_div == '0) || w_wrap);
  assign o_applied = w_apply;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_div  <= CNT_W'(DEF_DIV);
      o_tick <= 1'b0;
    end else begin
      if (w_apply) begin
        r_div <= i_ld_div;
      end
      // Every apply path lands in a branch that clears the counter.
      if (w_wrap) begin
        r_cnt  <= '0;
        o_tick <= 1'b1;
      end else if (w_run) begin
        r_cnt  <= r_cnt + CNT_W'(1);
        o_tick <= 1'b0;
      end else begin
        r_cnt  <= '0;
        o_tick <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/tick_sched.sv
// rtl/tick_sched.sv - multi-channel clock-enable tick scheduler
// Purpose: N_CH divide-by-D tick channels with a single-slot divisor update
//          port applied glitch-free at each target channel's next wrap.
// Ports:   clk, rst_n   clock, async active-low reset
//          en           global run enable (0 holds all counters at 0)
//          sync         one-cycle pulse zeroing all counters together
//          cfg          config request port (tick_sched_if slave)
//          tick         per-channel registered one-cycle enable pulses
module tick_sched import tick_pkg::*; #(
  parameter int N_CH    = TICK_N_CH,
  parameter int CNT_W   = TICK_CNT_W,
  parameter int DEF_DIV = TICK_DEF_DIV
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic            sync,
  tick_sched_if.slave     cfg,
  output logic [N_CH-1:0] tick
);

  localparam int CH_W = ch_width(N_CH);

  pend_state_t      r_state;
  pend_state_t      w_state_nxt;
  logic [CH_W-1:0]  r_pend_ch;
  logic [CNT_W-1:0] r_pend_div;
  logic             r_err;
  logic             w_ready;
  logic             w_accept;
  logic             w_bad_ch;
  logic             w_ld_now;
  logic [N_CH-1:0]  w_ld;
  logic [N_CH-1:0]  w_applied;

  assign w_accept = cfg.cfg_valid && w_ready;
  assign w_bad_ch = (int'(cfg.cfg_ch) >= N_CH);
  assign w_ld_now = !en || sync;

  for (genvar g = 0; g < N_CH; g++) begin : g_chan
    assign w_ld[g] = (r_state == PEND_FULL) && (r_pend_ch == CH_W'(g));

    tick_chan #(
      .CNT_W   (CNT_W),
      .DEF_DIV (DEF_DIV)
    ) u_chan (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_en      (en),
      .i_sync    (sync),
      .i_ld      (w_ld[g]),
      .i_ld_div  (r_pend_div),
      .i_ld_now  (w_ld_now),
      .o_tick    (tick[g]),
      .o_applied (w_applied[g])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= PEND_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Out-of-range requests are consumed without occupying the slot.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      PEND_EMPTY: if (w_accept && !w_bad_ch) w_state_nxt = PEND_FULL;
      PEND_FULL:  if (|w_applied)            w_state_nxt = PEND_EMPTY;
      default:                               w_state_nxt = PEND_EMPTY;
    endcase
  end

  always_comb begin
    w_ready       = (r_state == PEND_EMPTY);
    cfg.cfg_ready = w_ready;
    cfg.cfg_err   = r_err;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend_ch  <= '0;
      r_pend_div <= '0;
      r_err      <= 1'b0;
    end else begin
      r_err <= w_accept && w_bad_ch;
      if (w_accept) begin
        r_pend_ch  <= cfg.cfg_ch;
        r_pend_div <= cfg.cfg_div;
      end
    end
  end

endmodule

// File: tb/tb_tick_sched.sv
// tb/tb_tick_sched.sv - scoreboard testbench for tick_sched
module tb_tick_sched;
  import tick_pkg::*;

  localparam int N_CH  = 3;
  localparam int CNT_W = 16;
  localparam int CH_W  = ch_width(N_CH);
  localparam int DEFD  = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            en;
  logic            sync;
  logic [N_CH-1:0] tick;

  tick_sched_if #(.N_CH(N_CH), .CNT_W(CNT_W)) cfg_if ();

  tick_sched #(
    .N_CH    (N_CH),
    .CNT_W   (CNT_W),
    .DEF_DIV (DEFD)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .sync  (sync),
    .cfg   (cfg_if),
    .tick  (tick)
  );

  always #5 clk = ~clk;

  typedef struct {
    int              cyc_no;
    logic [N_CH-1:0] tick;
    logic            ready;
    logic            err;
  } exp_t;

  typedef struct {
    int ch;
    int dv;
  } req_t;

  exp_t sb_q[$];
  req_t req_q[$];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  bit en_v;
  bit rst_v;

  // Reference model: each channel remembers its divisor and the edge at which
  // its current period started; a tick is due exactly div edges later.
  int m_div [N_CH];
  int m_start [N_CH];
  bit m_pend;
  int m_pch;
  int m_pdiv;
  bit m_err;

  task automatic chk(input string nm, input int act, input int exp_v);
    n_checks++;
    if (act != exp_v) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", nm, cyc, act, exp_v);
    end
  endtask

  function automatic void model_reset(input int k);
    for (int i = 0; i < N_CH; i++) begin
      m_div[i]   = DEFD;
      m_start[i] = k;
    end
    m_pend = 1'b0;
    m_err  = 1'b0;
  endfunction

  task automatic push_req(input int ch, input int dv);
    req_t r;
    r.ch = ch;
    r.dv = dv;
    req_q.push_back(r);
  endtask

  // Drives the inputs for the next edge and queues what that edge must produce.
  task automatic step(input bit s_pulse);
    exp_t            e;
    req_t            r;
    int              k;
    bit              acc;
    bit              run;
    bit              cond;
    logic [N_CH-1:0] t;
    @(posedge clk);
    #1;
    k     = cyc + 1;
    rst_n = rst_v;
    en    = en_v;
    sync  = s_pulse;
    if (req_q.size() > 0) begin
      cfg_if.cfg_valid = 1'b1;
      cfg_if.cfg_ch    = CH_W'(req_q[0].ch);
      cfg_if.cfg_div   = CNT_W'(req_q[0].dv);
    end else begin
      cfg_if.cfg_valid = 1'b0;
      cfg_if.cfg_ch    = CH_W'($urandom_range(0, 3));
      cfg_if.cfg_div   = CNT_W'($urandom_range(0, 65535));
    end
    t = '0;
    if (!rst_v) begin
      model_reset(k);
    end else begin
      acc = (req_q.size() > 0) && !m_pend;
      for (int i = 0; i < N_CH; i++) begin
        run  = en_v && !s_pulse && (m_div[i] > 0);
        t[i] = run && ((k - m_start[i]) == m_div[i]);
        if (!run || t[i]) m_start[i] = k;
      end
      if (m_pend) begin
        cond = !en_v || s_pulse || (m_div[m_pch] == 0) || t[m_pch];
        if (cond) begin
          m_div[m_pch] = m_pdiv;
          m_pend       = 1'b0;
        end
      end
      m_err = 1'b0;
      if (acc) begin
        r = req_q.pop_front();
        if (r.ch >= N_CH) begin
          m_err = 1'b1;
        end else begin
          m_pend = 1'b1;
          m_pch  = r.ch;
          m_pdiv = r.dv;
        end
      end
    end
    e.cyc_no = k;
    e.tick   = t;
    e.ready  = !m_pend;
    e.err    = m_err;
    sb_q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #3;
      while (sb_q.size() > 0 && sb_q[0].cyc_no == cyc) begin
        e = sb_q.pop_front();
        chk("tick", int'(tick), int'(e.tick));
        chk("cfg_ready", int'(cfg_if.cfg_ready), int'(e.ready));
        chk("cfg_err", int'(cfg_if.cfg_err), int'(e.err));
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin : main
    rst_n            = 1'b1;
    en               = 1'b0;
    sync             = 1'b0;
    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_ch    = '0;
    cfg_if.cfg_div   = '0;
    en_v             = 1'b0;
    rst_v            = 1'b0;
    model_reset(0);

    #2 rst_n = 1'b0;
    #1;
    chk("rst_tick", int'(tick), 0);
    chk("rst_ready", int'(cfg_if.cfg_ready), 1);
    chk("rst_err", int'(cfg_if.cfg_err), 0);
    repeat (3) step(1'b0);
    rst_v = 1'b1;
    step(1'b0);

    // defaults, divide-by-2 on every channel
    en_v = 1'b1;
    repeat (10) step(1'b0);

    // ch1 to 5 while running
    push_req(CH_BAUD, 5);
    repeat (20) step(1'b0);

    // ch0 disable then divide-by-3
    push_req(CH_PIX, 0);
    repeat (5) step(1'b0);
    push_req(CH_PIX, 3);
    repeat (10) step(1'b0);

    // ch2 divide-by-1 written while idle
    en_v = 1'b0;
    push_req(CH_SCAN, 1);
    repeat (3) step(1'b0);
    en_v = 1'b1;
    repeat (6) step(1'b0);

    // ch0=4, ch1=6, then phase align
    push_req(CH_PIX, 4);
    push_req(CH_BAUD, 6);
    repeat (17) step(1'b0);
    step(1'b1);
    repeat (30) step(1'b0);

    // out-of-range channel
    push_req(3, 7);
    repeat (4) step(1'b0);

    // reset while an update is pending
    push_req(CH_BAUD, 9);
    step(1'b0);
    @(posedge clk);
    #5;
    rst_v = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("async_rst_tick", int'(tick), 0);
    chk("async_rst_ready", int'(cfg_if.cfg_ready), 1);
    chk("async_rst_err", int'(cfg_if.cfg_err), 0);
    repeat (2) step(1'b0);
    rst_v = 1'b1;
    step(1'b0);
    repeat (12) step(1'b0);

    // randomized traffic
    repeat (400) begin
      en_v = ($urandom_range(0, 15) != 0);
      if (req_q.size() == 0 && $urandom_range(0, 4) == 0)
        push_req(int'($urandom_range(0, 3)), int'($urandom_range(0, 7)));
      step($urandom_range(0, 24) == 0);
    end

    repeat (3) @(posedge clk);
    #4;
    chk("sb_drain", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tick_sched.md
Name: tick_sched

Overview:
- Multi-channel clock-enable scheduler. Replaces ad-hoc toggle dividers with single-domain tick pulses: one `clk`, N programmable divide-by-D enables.
- Consumers include VGA pixel, UART baud and 7-seg refresh.
- Owns the divisor registers and accepts runtime divisor changes over a valid/ready config port.
- Applies each change glitch-free at the target channel's next wrap.

Parameters:
- N_CH, 3, number of tick channels.
- CNT_W, 16, width of divisor and per-channel counter.
- DEF_DIV, 2, reset divisor loaded into every channel (divide-by-2).

Ports:
- clk  input  1  system clock, all logic on posedge.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  global run enable; 0 holds all counters at 0.
- sync  input  1  one-cycle pulse; zeroes all channel counters together (phase align).
- cfg_valid  input  1  config request valid.
- cfg_ready  output  1  config slot free; a transfer occurs when valid && ready at posedge.
- cfg_ch  input  max(1,$clog2(N_CH))  target channel index.
- cfg_div  input  CNT_W  new divisor; 0 disables the channel.
- cfg_err  output  1  one-cycle pulse: accepted request had cfg_ch >= N_CH.
- tick  output  N_CH  per-channel one-cycle enable pulses, registered.

Behaviour:
- Reset, asynchronous on rst_n low, values:
  - cnt[i]=0, div[i]=DEF_DIV.
  - tick=0, cfg_ready=1, cfg_err=0.
  - Pending slot empty.
- Per-channel state is IDLE (en=0) or RUN (en=1). There is no other FSM state.
- IDLE:
  - cnt[i] is held at 0 and tick is 0.
  - Any pending update is applied at the next posedge.
- RUN, at each posedge, for channel i with div[i]>=1:
  - If cnt[i]==div[i]-1: cnt[i]<=0, tick[i]<=1.
  - Otherwise: cnt[i]<=cnt[i]+1, tick[i]<=0.
  - The first tick is high after the div-th posedge with en=1.
  - Period is exactly div cycles and the duty is one cycle.
- div[i]==1: tick[i] is high every cycle while en=1.
- div[i]==0: channel disabled; cnt[i] held 0, tick[i]=0.
- sync=1 at a posedge:
  - All cnt<=0 and all tick<=0 in that cycle.
  - Overrides wrap and increment.
  - Has no effect when en=0.
- Config handshake:
  - Accept captures {cfg_ch, cfg_div} into the single pending slot; cfg_ready falls the next cycle.
  - Pending is applied to the target channel when either:
    - that channel wraps (the cnt==div-1 edge): the wrap tick is still emitted with the old period, cnt<=0, div<=new; or
    - en=0, or the channel's div is 0, or sync=1: div<=new at the next posedge, cnt<=0.
  - cfg_ready returns to 1 the cycle after apply. Apply and a new accept never share an edge.
- cfg_ch >= N_CH:
  - The request is accepted and dropped.
  - cfg_err pulses the cycle after accept; cfg_ready stays 1.
- Reset mid-operation: pending is discarded and all div return to DEF_DIV.
- en falling mid-period: the partial count is lost and the count restarts from 0 on re-enable.
- Width:
  - cnt compares against div-1 computed in CNT_W bits.
  - The maximum period is 2^CNT_W-1 cycles.

Decomposition:
- Shared package tick_pkg:
  - CNT_W default.
  - DEF_DIV.
  - Channel index constants (CH_PIX=0, CH_BAUD=1, CH_SCAN=2).
- Sub-module tick_chan, instantiated N_CH times:
  - Contents: counter, wrap detect, div register, load port (ld, ld_div, ld_now).
- Top contains:
  - Pending slot.
  - Handshake.
  - Decode.
  - Error pulse.

Test Plan:
1. Reset then en=1, defaults: every tick[i] pulses on posedges 2, 4, 6… after en; cfg_ready=1.
2. Write ch1 div=5 while running div=2:
   - ch1 emits the old-period wrap tick, then ticks every 5 cycles.
   - cfg_ready is low until the cycle after the wrap.
   - Other channels are unaffected.
3. Write ch0 div=0, then div=3:
   - Disable is applied at the next edge and tick[0] stays 0.
   - The re-enable applies next edge; the first tick comes 3 cycles later.
4. Hold en=0, write ch2 div=1, raise en: tick[2] is high every cycle starting from the first edge with en=1.
5. Set ch0 div=4 and ch1 div=6 with offset phases, pulse sync: both cnt go to 0; tick[0] fires 4 cycles later and tick[1] fires 6 cycles later, and both coincide every 12 cycles.
6. cfg_ch=3 with N_CH=3: cfg_err pulses once, no div changes. Then assert rst_n low mid-pending: all outputs reach reset values asynchronously, pending is cleared and div returns to 2.
